alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 42 ++++
 rtl/alu_sequencer_op_decode.sv | 33 +++
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants, instruction layout and sequencer state encoding.
package alu_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WIDE_W = 64;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned RSVD_W = 15;

    // Opcodes understood by the ALU; anything else is rejected at issue.
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    // Instruction word: opcode[31:27], ra[26:23], rb[22:19], rc[18:15], unused[14:0].
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [REG_W-1:0]  ra;
        logic [REG_W-1:0]  rb;
        logic [REG_W-1:0]  rc;
        logic [RSVD_W-1:0] rsvd;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_Y = 3'd1,
        ST_READ_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_sequencer_op_decode.sv
// Opcode classifier: legality, single-operand ops, and ops writing HI/LO.
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output logic            legal,
    output logic            is_unary,
    output logic            is_hilo
);

    // Pure decode of the opcode constants.
    always_comb begin
        legal    = 1'b0;
        is_unary = 1'b0;
        is_hilo  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL: begin
                legal = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                legal   = 1'b1;
                is_hilo = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                legal    = 1'b1;
                is_unary = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetch operands from the register file, run the
// external ALU, then write the result back to the RF or to HI/LO.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DATA_W-1:0]     instr,
    output logic                  ready,
    output logic [REG_W-1:0]      rf_rsel,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic [DATA_W-1:0]     alu_y,
    output logic [DATA_W-1:0]     alu_b,
    output logic [OP_W-1:0]       alu_op,
    input  logic [WIDE_W-1:0]     alu_c,
    output logic                  rf_we,
    output logic [REG_W-1:0]      rf_wsel,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  hi_we,
    output logic                  lo_we,
    output logic [DATA_W-1:0]     hi_wdata,
    output logic [DATA_W-1:0]     lo_wdata,
    output logic                  done,
    output logic                  illegal
);

    state_t              state_q, state_d;
    instr_t              instr_s, ir_q;
    logic [DATA_W-1:0]   y_q, b_q;
    logic [WIDE_W-1:0]   z_q;
    logic                illegal_q;

    logic                in_legal, in_unary;
    logic                ir_unary, ir_hilo;
    logic                unused_in_hilo, unused_ir_legal;
    logic [2*RSVD_W-1:0] unused_rsvd;

    assign instr_s     = instr_t'(instr);
    assign unused_rsvd = {ir_q.rsvd, instr_s.rsvd};

    // Classifies the offered instruction for acceptance.
    alu_op_decode u_dec_in (
        .opcode   (instr_s.opcode),
        .legal    (in_legal),
        .is_unary (in_unary),
        .is_hilo  (unused_in_hilo)
    );

    // Classifies the latched instruction for operand routing and write-back.
    alu_op_decode u_dec_ir (
        .opcode   (ir_q.opcode),
        .legal    (unused_ir_legal),
        .is_unary (ir_unary),
        .is_hilo  (ir_hilo)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs from state plus latched instruction.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        rf_rsel = ir_q.rb;
        alu_op  = ir_q.opcode;
        rf_we   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready  = 1'b1;
                alu_op = '0;
                if (start && in_legal) begin
                    state_d = in_unary ? ST_READ_B : ST_READ_Y;
                end
            end
            ST_READ_Y: begin
                state_d = ST_READ_B;
            end
            ST_READ_B: begin
                if (!ir_unary) begin
                    rf_rsel = ir_q.rc;
                end
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                done = 1'b1;
                if (ir_hilo) begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                end else begin
                    rf_we = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Instruction, operand and result registers plus the illegal-opcode flag.
    always_ff @(posedge clock) begin
        if (clear) begin
            ir_q      <= '0;
            y_q       <= '0;
            b_q       <= '0;
            z_q       <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (state_q == ST_IDLE) && start && !in_legal;
            case (state_q)
                ST_IDLE: begin
                    if (start && in_legal) begin
                        ir_q <= instr_s;
                    end
                end
                ST_READ_Y: begin
                    y_q <= rf_rdata;
                end
                ST_READ_B: begin
                    b_q <= rf_rdata;
                    if (ir_unary) begin
                        y_q <= '0;
                    end
                end
                ST_EXEC: begin
                    z_q <= alu_c;
                end
                default: ;
            endcase
        end
    end

    assign alu_y    = y_q;
    assign alu_b    = b_q;
    assign rf_wsel  = ir_q.ra;
    assign rf_wdata = z_q[DATA_W-1:0];
    assign lo_wdata = z_q[DATA_W-1:0];
    assign hi_wdata = z_q[WIDE_W-1:DATA_W];
    assign illegal  = illegal_q;

endmodule
